// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
// Front-end between the core LSU request/response bus and port 0 of the
// on-chip data SRAM. Checks size/alignment, builds the byte write mask and
// the lane-replicated write data, drives the SRAM pins combinationally from
// the accepting request, and returns read data / write acks strictly in
// request order through a 2-entry response FIFO.
//
// Ports:
//   clock, reset          - single clock (also SRAM clk0), async active-high reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 = store, 0 = load
//   req_addr              - byte address (ADDR_WIDTH+2 bits)
//   req_size              - 0 byte, 1 half, 2 word, 3 illegal
//   req_wdata             - store data, LSB-justified
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - SRAM word for loads, 0 for stores and errors
//   rsp_write, rsp_err    - echoed write flag, misaligned/illegal flag
//   csb0, web0, wmask0,
//   addr0, din0, dout0    - SRAM port-0 pins
module sram_port_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_write,
    output logic                    rsp_err,
    output logic                    csb0,
    output logic                    web0,
    output logic [NUM_WMASKS-1:0]   wmask0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH-1:0]   dout0
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    size_e                  size;
    logic [1:0]             b;
    logic                   err;
    logic                   fire;
    logic                   access;
    logic                   pop;
    logic                   push;
    logic [2:0]             occupancy;
    logic [NUM_WMASKS-1:0]  lane_mask;
    logic [DATA_WIDTH-1:0]  wdata_rep;

    // In-flight slot: the SRAM access issued last cycle, waiting for dout0.
    logic                   inflight;
    logic                   if_write;
    logic                   if_err;

    // Response FIFO, 2 entries, 1-bit wrapping pointers.
    logic [DATA_WIDTH-1:0]  fifo_rdata [2];
    logic                   fifo_write [2];
    logic                   fifo_err   [2];
    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;

    assign size = size_e'(req_size);
    assign b    = req_addr[1:0];

    always_comb begin
        err = 1'b0;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = b[0];
            SZ_WORD: err = (b != 2'b00);
            SZ_BAD:  err = 1'b1;
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        lane_mask = '0;
        wdata_rep = '0;
        case (size)
            SZ_BYTE: begin
                lane_mask = 4'b0001 << b;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = 4'b0011 << b;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                lane_mask = 4'b1111;
                wdata_rep = req_wdata;
            end
            default: begin
                lane_mask = '0;
                wdata_rep = '0;
            end
        endcase
    end

    // A response slot is freed in the same cycle it is popped, which is what
    // lets one request per cycle through while rsp_ready stays high.
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign req_ready = !reset && (occupancy < 3'd2);
    assign fire      = req_valid && req_ready;
    assign access    = fire && !err;

    assign csb0   = !access;
    assign web0   = !(access && req_write);
    assign wmask0 = (access && req_write) ? lane_mask : '0;
    assign addr0  = req_addr[ADDR_WIDTH+1:2];
    assign din0   = req_write ? wdata_rep : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            if_write <= 1'b0;
            if_err   <= 1'b0;
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_rdata[i] <= '0;
                fifo_write[i] <= 1'b0;
                fifo_err[i]   <= 1'b0;
            end
        end else begin
            inflight <= fire;
            if (fire) begin
                if_write <= req_write;
                if_err   <= err;
            end
            // dout0 is valid the cycle after the SRAM sampled the read.
            if (push) begin
                fifo_rdata[wr_ptr] <= (!if_write && !if_err) ? dout0 : '0;
                fifo_write[wr_ptr] <= if_write;
                fifo_err[wr_ptr]   <= if_err;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rsp_valid = (count != 2'd0);
    assign rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : '0;
    assign rsp_write = rsp_valid ? fifo_write[rd_ptr] : 1'b0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl with a behavioural SRAM.
module tb_sram_port_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [13:0] addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        cap_csb;
    logic        cap_web;
    logic [3:0]  cap_wmask;
    logic [13:0] cap_addr;
    logic [31:0] cap_din;

    typedef struct {
        logic [31:0] rdata;
        logic        write;
        logic        err;
        int          cyc;
    } rsp_t;
    rsp_t rq[$];

    logic [31:0] mem [0:255];

    sram_port_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_err(rsp_err),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural SRAM: synchronous read, byte-masked write.
    always @(posedge clock) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) mem[addr0[7:0]][i*8 +: 8] <= din0[i*8 +: 8];
            end else begin
                dout0 <= mem[addr0[7:0]];
            end
        end
    end

    // Record every response handshake together with its cycle number.
    always @(negedge clock)
        if (rsp_valid && rsp_ready) rq.push_back('{rsp_rdata, rsp_write, rsp_err, cyc});

    task automatic send(input logic w, input logic [15:0] a, input logic [1:0] s,
                        input logic [31:0] d, output int acc);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout req_ready=%b required 1", req_ready);
        end
        cap_csb = csb0; cap_web = web0; cap_wmask = wmask0; cap_addr = addr0; cap_din = din0;
        acc = cyc;
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_wdata = '0;
    endtask

    task automatic get_rsp(output rsp_t r);
        int n = 0;
        while (rq.size() == 0 && n < 30) begin
            @(posedge clock); #1; n++;
        end
        if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout no response within 30 cycles");
            r = '{32'h0, 1'b0, 1'b0, -1};
        end else begin
            r = rq.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 16'h0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h expected 0", rsp_rdata); end
        checks++; if ({rsp_err, rsp_write} !== 2'b00) begin errors++; $display("FAIL reset_rsp_flags got %b expected 00", {rsp_err, rsp_write}); end
        checks++; if ({csb0, web0} !== 2'b11) begin errors++; $display("FAIL reset_csb_web got %b expected 11", {csb0, web0}); end
        checks++; if (wmask0 !== 4'h0) begin errors++; $display("FAIL reset_wmask got %h expected 0", wmask0); end
        req_valid = 1'b0; req_write = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_word();
        int acc; rsp_t r;
        rsp_ready = 1'b1;
        send(1'b1, 16'h10, 2'd2, 32'hDEADBEEF, acc);
        checks++; if ({cap_csb, cap_web} !== 2'b00) begin errors++; $display("FAIL word_store_csb_web got %b expected 00", {cap_csb, cap_web}); end
        checks++; if (cap_wmask !== 4'hF) begin errors++; $display("FAIL word_store_wmask got %h expected f", cap_wmask); end
        checks++; if (cap_addr !== 14'd4) begin errors++; $display("FAIL word_store_addr got %h expected 4", cap_addr); end
        checks++; if (cap_din !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_din got %h expected deadbeef", cap_din); end
        get_rsp(r);
        checks++; if ({r.write, r.err, r.rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL word_store_rsp got w=%b e=%b d=%h expected w=1 e=0 d=0", r.write, r.err, r.rdata); end
        send(1'b0, 16'h10, 2'd2, 32'h0, acc);
        checks++; if ({cap_csb, cap_web, cap_wmask} !== 6'b01_0000) begin errors++; $display("FAIL word_load_pins got %b expected 010000", {cap_csb, cap_web, cap_wmask}); end
        get_rsp(r);
        checks++; if ({r.write, r.err, r.rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL word_load_rsp got w=%b e=%b d=%h expected w=0 e=0 d=deadbeef", r.write, r.err, r.rdata); end
        checks++; if (r.cyc - acc !== 2) begin errors++; $display("FAIL word_load_latency got %0d expected 2", r.cyc - acc); end
    endtask

    task automatic test_byte_half();
        int acc; rsp_t r;
        send(1'b1, 16'h13, 2'd0, 32'h000000A5, acc);
        checks++; if (cap_wmask !== 4'b1000) begin errors++; $display("FAIL byte_wmask got %b expected 1000", cap_wmask); end
        checks++; if (cap_din !== 32'hA5A5A5A5) begin errors++; $display("FAIL byte_din got %h expected a5a5a5a5", cap_din); end
        get_rsp(r);
        send(1'b0, 16'h10, 2'd2, 32'h0, acc);
        get_rsp(r);
        checks++; if (r.rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL byte_readback got %h expected a5adbeef", r.rdata); end
        send(1'b1, 16'h12, 2'd1, 32'h00001234, acc);
        checks++; if (cap_wmask !== 4'b1100) begin errors++; $display("FAIL half_wmask got %b expected 1100", cap_wmask); end
        checks++; if (cap_din !== 32'h12341234) begin errors++; $display("FAIL half_din got %h expected 12341234", cap_din); end
        get_rsp(r);
        send(1'b0, 16'h10, 2'd2, 32'h0, acc);
        get_rsp(r);
        checks++; if (r.rdata !== 32'h1234BEEF) begin errors++; $display("FAIL half_readback got %h expected 1234beef", r.rdata); end
    endtask

    task automatic test_errors();
        int acc; rsp_t r; logic [2:0] cs; logic [2:0] exp_w;
        exp_w = 3'b100;
        send(1'b1, 16'h11, 2'd1, 32'h0000FFFF, acc); cs[2] = cap_csb;
        send(1'b0, 16'h12, 2'd2, 32'h0, acc);        cs[1] = cap_csb;
        send(1'b0, 16'h10, 2'd3, 32'h0, acc);        cs[0] = cap_csb;
        checks++; if (cs !== 3'b111) begin errors++; $display("FAIL err_csb got %b expected 111", cs); end
        for (int i = 0; i < 3; i++) begin
            get_rsp(r);
            checks++;
            if ({r.err, r.write, r.rdata} !== {1'b1, exp_w[2-i], 32'h0}) begin
                errors++;
                $display("FAIL err_rsp%0d got e=%b w=%b d=%h expected e=1 w=%b d=0", i, r.err, r.write, r.rdata, exp_w[2-i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc; int idx; int n; rsp_t r;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 16'h20 + 16'(4*i), 2'd2, 32'hC0DE0000 + 32'(i), acc);
            get_rsp(r);
        end
        rsp_ready = 1'b0; idx = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 16'h20;
        for (int c = 0; c < 6; c++) begin
            #1; if (req_ready) idx++;
            @(posedge clock); #1;
            req_addr = 16'h20 + 16'(4*idx);
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepts got %0d expected 2", idx); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b expected 0", req_ready); end
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hC0DE0000}) begin errors++; $display("FAIL bp_head got v=%b d=%h expected v=1 d=c0de0000", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1; n = 0;
        while (idx < 4 && n < 20) begin
            #1; if (req_ready) idx++;
            @(posedge clock); #1;
            req_addr = 16'h20 + 16'(4*idx);
            req_valid = (idx < 4);
            n++;
        end
        req_valid = 1'b0;
        checks++; if (idx !== 4) begin errors++; $display("FAIL bp_total_accepts got %0d expected 4", idx); end
        for (int i = 0; i < 4; i++) begin
            get_rsp(r);
            checks++;
            if ({r.err, r.rdata} !== {1'b0, 32'hC0DE0000 + 32'(i)}) begin
                errors++;
                $display("FAIL bp_drain%0d got e=%b d=%h expected e=0 d=%h", i, r.err, r.rdata, 32'hC0DE0000 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first; int notready; rsp_t r;
        rsp_ready = 1'b1; notready = 0; first = 0;
        req_write = 1'b0; req_size = 2'd2;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = 16'h20 + 16'(4*(i%4));
            #1;
            if (!req_ready) notready++;
            if (i == 0) first = cyc;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        checks++; if (notready !== 0) begin errors++; $display("FAIL b2b_ready_drops got %0d expected 0", notready); end
        for (int i = 0; i < 8; i++) begin
            get_rsp(r);
            checks++;
            if (r.rdata !== 32'hC0DE0000 + 32'(i%4) || r.cyc !== first + 2 + i) begin
                errors++;
                $display("FAIL b2b_rsp%0d got d=%h cyc=%0d expected d=%h cyc=%0d", i, r.rdata, r.cyc, 32'hC0DE0000 + 32'(i%4), first + 2 + i);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int acc;
        rsp_ready = 1'b0;
        send(1'b0, 16'h20, 2'd2, 32'h0, acc);
        send(1'b0, 16'h24, 2'd2, 32'h0, acc);
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_fly_rsp_valid got %b expected 0", rsp_valid); end
        rq.delete();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0; rsp_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_fly_ready got %b expected 1", req_ready); end
        repeat (5) @(posedge clock);
        #1;
        checks++; if (rq.size() !== 0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_fly_stale got %0d responses expected 0", rq.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
